// File: rtl/reorder_fifo.sv
// In-order reorder buffer between dispatch and commit.
// Circular storage with wrap-bit pointers; full/empty/cnt registered from next-state pointers.
module reorder_fifo #(
    parameter int unsigned DW = 78,
    parameter int unsigned AW = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          reOrder_fifo_push,
    input  logic [DW-1:0] dispat_info,
    output logic          reOrder_fifo_full,
    input  logic          reOrder_fifo_pop,
    output logic [DW-1:0] commit_fifo,
    output logic          reOrder_fifo_empty,
    input  logic          flush,
    output logic [AW:0]   reOrder_fifo_cnt
);

    localparam int unsigned DP = 2 ** AW;

    logic [DW-1:0] storage [DP];
    logic [AW:0]   rdPtr;
    logic [AW:0]   wrPtr;
    logic [AW:0]   rdPtrNxt;
    logic [AW:0]   wrPtrNxt;
    logic          fullNxt;
    logic          emptyNxt;
    logic [AW:0]   cntNxt;
    logic          pushOk;
    logic          popOk;

    // Acceptance uses the registered flags, so a pop on full never frees a slot for the same-cycle push.
    assign pushOk = reOrder_fifo_push & ~reOrder_fifo_full;
    assign popOk  = reOrder_fifo_pop & ~reOrder_fifo_empty;

    always_comb begin
        rdPtrNxt = rdPtr;
        wrPtrNxt = wrPtr;
        if (flush) begin
            rdPtrNxt = '0;
            wrPtrNxt = '0;
        end else begin
            if (popOk) begin
                rdPtrNxt = rdPtr + (AW+1)'(1);
            end
            if (pushOk) begin
                wrPtrNxt = wrPtr + (AW+1)'(1);
            end
        end
        fullNxt  = (wrPtrNxt[AW-1:0] == rdPtrNxt[AW-1:0]) && (wrPtrNxt[AW] != rdPtrNxt[AW]);
        emptyNxt = (wrPtrNxt == rdPtrNxt);
        cntNxt   = wrPtrNxt - rdPtrNxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdPtr              <= '0;
            wrPtr              <= '0;
            reOrder_fifo_full  <= 1'b0;
            reOrder_fifo_empty <= 1'b1;
            reOrder_fifo_cnt   <= '0;
        end else begin
            rdPtr              <= rdPtrNxt;
            wrPtr              <= wrPtrNxt;
            reOrder_fifo_full  <= fullNxt;
            reOrder_fifo_empty <= emptyNxt;
            reOrder_fifo_cnt   <= cntNxt;
        end
    end

    // Storage is not reset; a write under flush or reset lands outside the valid window.
    always_ff @(posedge CLK) begin
        if (pushOk) begin
            storage[wrPtr[AW-1:0]] <= dispat_info;
        end
    end

    assign commit_fifo = reOrder_fifo_empty ? '0 : storage[rdPtr[AW-1:0]];

endmodule
